// File: rtl/rr_mux4_arbiter_pkg.sv
// Shared definitions for the round-robin 4:1 mux arbiter: state encodings,
// requester count, hold counter width and a one-hot helper.
package rr_mux4_arbiter_pkg;

  localparam int NREQ   = 4;
  localparam int HOLD_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Convert a requester index into its one-hot grant vector.
  function automatic logic [NREQ-1:0] idx_to_onehot(input logic [1:0] idx);
    logic [NREQ-1:0] vec;
    vec      = {NREQ{1'b0}};
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/rr_mux4_arbiter_mux4_1.sv
// Behavioural 4:1 single-bit multiplexer shared by the four requesters.
module mux4_1 (
  input  logic [3:0] in,
  input  logic [1:0] select,
  output logic       out
);

  // Route the selected input bit to the output.
  always_comb begin
    out = 1'b0;
    case (select)
      2'd0:    out = in[0];
      2'd1:    out = in[1];
      2'd2:    out = in[2];
      2'd3:    out = in[3];
      default: out = 1'b0;
    endcase
  end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter in front of a 4:1 mux. Grants one requester at a time,
// drives the mux select from the registered grant, and bounds how long an
// owner may keep the path while somebody else is waiting.
module rr_mux4_arbiter
  import rr_mux4_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] data_in,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       valid,
  output logic       data_out
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = {{(HOLD_W-1){1'b0}}, 1'b1};

  state_t            state_r;
  state_t            state_n;
  logic [1:0]        ptr_r;
  logic [1:0]        ptr_n;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic [HOLD_W-1:0] hold_cnt_n;
  logic [NREQ-1:0]   gnt_r;
  logic [NREQ-1:0]   gnt_n;
  logic [1:0]        sel_r;
  logic [1:0]        sel_n;
  logic              valid_r;
  logic              valid_n;

  logic [NREQ-1:0]   search_mask_s;
  logic [1:0]        cand_s;
  logic [1:0]        win_idx_s;
  logic              win_found_s;
  logic              owner_req_s;
  logic              others_req_s;
  logic              release_s;
  logic              mux_out_s;

  // Rotating winner search starting just after the last granted index.
  // While a grant is active the current owner is masked out, so a release
  // always hands over to somebody else.
  always_comb begin
    search_mask_s = (state_r == ST_GRANT) ? (req & ~gnt_r) : req;
    cand_s        = 2'd0;
    win_idx_s     = 2'd0;
    win_found_s   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = ptr_r + 2'(k);
      if (!win_found_s && search_mask_s[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Release decision for the current owner.
  always_comb begin
    owner_req_s  = req[sel_r];
    others_req_s = |(req & ~gnt_r);
    release_s    = !owner_req_s || ((hold_cnt_r == HOLD_MAX) && others_req_s);
  end

  // Next-state and next-output logic of the two-state arbiter.
  always_comb begin
    state_n    = state_r;
    ptr_n      = ptr_r;
    hold_cnt_n = hold_cnt_r;
    gnt_n      = gnt_r;
    sel_n      = sel_r;
    valid_n    = valid_r;
    case (state_r)
      ST_IDLE: begin
        if (win_found_s) begin
          state_n    = ST_GRANT;
          ptr_n      = win_idx_s;
          hold_cnt_n = HOLD_ONE;
          gnt_n      = idx_to_onehot(win_idx_s);
          sel_n      = win_idx_s;
          valid_n    = 1'b1;
        end else begin
          gnt_n   = {NREQ{1'b0}};
          valid_n = 1'b0;
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          if (win_found_s) begin
            // Direct handover, no idle bubble between owners.
            ptr_n      = win_idx_s;
            hold_cnt_n = HOLD_ONE;
            gnt_n      = idx_to_onehot(win_idx_s);
            sel_n      = win_idx_s;
            valid_n    = 1'b1;
          end else begin
            state_n    = ST_IDLE;
            hold_cnt_n = {HOLD_W{1'b0}};
            gnt_n      = {NREQ{1'b0}};
            valid_n    = 1'b0;
          end
        end else begin
          // Owner keeps the path; the counter saturates so a sole
          // requester is never forced off.
          if (hold_cnt_r < HOLD_MAX) begin
            hold_cnt_n = hold_cnt_r + HOLD_ONE;
          end else begin
            hold_cnt_n = hold_cnt_r;
          end
        end
      end
      default: begin
        state_n    = ST_IDLE;
        hold_cnt_n = {HOLD_W{1'b0}};
        gnt_n      = {NREQ{1'b0}};
        valid_n    = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset leaves requester 0 with first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      ptr_r      <= 2'b11;
      hold_cnt_r <= {HOLD_W{1'b0}};
      gnt_r      <= {NREQ{1'b0}};
      sel_r      <= 2'b00;
      valid_r    <= 1'b0;
    end else begin
      state_r    <= state_n;
      ptr_r      <= ptr_n;
      hold_cnt_r <= hold_cnt_n;
      gnt_r      <= gnt_n;
      sel_r      <= sel_n;
      valid_r    <= valid_n;
    end
  end

  mux4_1 u_mux (
    .in     (data_in),
    .select (sel_r),
    .out    (mux_out_s)
  );

  // Drive ports; data_out is gated so an idle path always reads 0.
  always_comb begin
    gnt      = gnt_r;
    sel      = sel_r;
    valid    = valid_r;
    data_out = mux_out_s & valid_r;
  end

endmodule
